// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter: one outstanding transaction at a time
// through an IDLE -> BUSY -> DONE sequence, with a timeout that forces completion.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 8;
    localparam logic [DW-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam logic [CW-1:0] TIMEOUT_CNT   = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic            s_valid_q, s_valid_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic [SW-1:0]   s_wstrb_q, s_wstrb_d;
    logic            m0_ready_q, m0_ready_d;
    logic            m1_ready_q, m1_ready_d;
    logic [DW-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]   m1_rdata_q, m1_rdata_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [CW-1:0]   wait_q, wait_d;

    logic            sel;
    logic [CW-1:0]   wait_inc;
    logic            timeout_hit;
    logic [DW-1:0]   cpl_rdata;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_valid_d    = s_valid_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_wstrb_d    = s_wstrb_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        busy_d       = busy_q;
        err_d        = err_q;
        wait_d       = wait_q;
        sel          = 1'b0;
        wait_inc     = wait_q + CW'(1);
        timeout_hit  = (wait_inc == TIMEOUT_CNT);
        cpl_rdata    = s_ready ? s_rdata : TIMEOUT_RDATA;

        case (state_q)
            IDLE: begin
                s_valid_d = 1'b0;
                busy_d    = 1'b0;
                if (m0_valid || m1_valid) begin
                    // On contention the requester that did not win last time goes first
                    sel          = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
                    grant_d      = sel;
                    last_grant_d = sel;
                    s_addr_d     = sel ? m1_addr  : m0_addr;
                    s_wdata_d    = sel ? m1_wdata : m0_wdata;
                    s_wstrb_d    = sel ? m1_wstrb : m0_wstrb;
                    s_valid_d    = 1'b1;
                    busy_d       = 1'b1;
                    wait_d       = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (s_ready || timeout_hit) begin
                    if (!s_ready) begin
                        err_d = 1'b1;
                    end
                    if (grant_q) begin
                        m1_rdata_d = cpl_rdata;
                        m1_ready_d = 1'b1;
                    end else begin
                        m0_rdata_d = cpl_rdata;
                        m0_ready_d = 1'b1;
                    end
                    s_valid_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    wait_d = wait_inc;
                end
            end
            DONE: begin
                // Controller ready here is a stale echo of the completed beat
                s_valid_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                s_valid_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            s_valid_q    <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_wstrb_q    <= '0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            s_valid_q    <= s_valid_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_wstrb_q    <= s_wstrb_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            wait_q       <= wait_d;
        end
    end

    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign s_valid  = s_valid_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles BUSY waits for s_ready before forced completion; legal range 2..255.
REQ-002 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Ports m0_valid/m1_valid  input  1  requester memory request (m0 = CPU, m1 = loader/DMA).
REQ-005 Ports m0_addr/m1_addr  input  32  byte address.
REQ-006 Ports m0_wdata/m1_wdata  input  32  write data.
REQ-007 Ports m0_wstrb/m1_wstrb  input  4  byte strobes; 4'b0000 = read.
REQ-008 Ports m0_ready/m1_ready  output  1  one-cycle completion pulse to requester.
REQ-009 Ports m0_rdata/m1_rdata  output  32  read data, valid while matching ready is high.
REQ-010 Ports s_valid  output  1;  s_addr  output  32;  s_wdata  output  32;  s_wstrb  output  4  request to memory controller.
REQ-011 Ports s_ready  input  1;  s_rdata  input  32  memory controller completion and read data.
REQ-012 Ports grant  output  1  index of requester owning current/last transaction; busy  output  1  high in BUSY or DONE; err  output  1  sticky timeout flag.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, BUSY, DONE; all outputs registered.
REQ-014 IDLE: if neither valid high, remain IDLE; s_valid=0.
REQ-015 IDLE, exactly one valid high: grant that requester, latch its addr/wdata/wstrb into s_addr/s_wdata/s_wstrb, go BUSY.
REQ-016 IDLE, both valid high: grant requester != last_grant (round robin), then as REQ-015.
REQ-017 last_grant SHALL update on every grant; reset value 1, so m0 wins the first contention.
REQ-018 BUSY: s_valid=1; s_addr/s_wdata/s_wstrb held constant, never re-sampled from requester mid-transaction.
REQ-019 BUSY with s_ready=1: capture s_rdata into granted mN_rdata, pulse granted mN_ready for one cycle, go DONE.
REQ-020 BUSY: 8-bit wait counter cleared on entry, incremented each BUSY cycle without s_ready; counter reaching TIMEOUT SHALL force completion per REQ-019 with rdata 32'hDEADBEEF and set err.
REQ-021 DONE: s_valid=0, both mN_ready=0, s_ready ignored (stale registered ready from controller); unconditionally go IDLE next cycle.
REQ-022 Latency: request sampled in IDLE at edge N -> s_valid high from N+1 -> with single-cycle controller, mN_ready high in cycle N+3; back-to-back transactions every 3 cycles.
REQ-023 Requester dropping valid while BUSY SHALL NOT abort the transaction; it completes and ready pulses.
REQ-024 Non-granted mN_ready SHALL stay 0; its mN_rdata SHALL hold its last value.
REQ-025 At most one of m0_ready/m1_ready high in any cycle; s_valid never high outside BUSY.
REQ-026 err SHALL be sticky until rst; no other effect on arbitration.

Reset
REQ-027 rst high at a clock edge SHALL force IDLE, s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0, m0/m1_ready=0, m0/m1_rdata=0, grant=0, busy=0, err=0, last_grant=1, wait counter=0.
REQ-028 rst asserted mid-transaction (BUSY or DONE) SHALL abandon it without any ready pulse; first post-reset grant follows REQ-016/017.

Verification
REQ-029 Single read: m0 addr 0x10, wstrb 0, controller returns 0x12345678 -> m0_ready one cycle, three cycles after request, m0_rdata=0x12345678, m1_ready=0.
REQ-030 Contention: m0 and m1 valid continuously -> grants alternate 0,1,0,1; each ready exactly one cycle; s_valid low in each DONE cycle.
REQ-031 Write: m1 addr 0x20, wdata 0xA5A5A5A5, wstrb 4'b0011 -> s_addr/s_wdata/s_wstrb match for entire BUSY, m1_ready pulses once, no m0_ready.
REQ-032 Timeout: s_ready tied 0, m0 read -> m0_ready after TIMEOUT BUSY cycles, m0_rdata=0xDEADBEEF, err=1 and stays 1 on next good transaction.
REQ-033 Reset mid-BUSY: assert rst one cycle while BUSY -> all outputs at reset values next cycle, no ready pulse, next contention grants m0.
REQ-034 Valid dropped in BUSY: m1 valid deasserted after grant -> transaction still completes, m1_ready pulses once.
